// File: rtl/alu_result_checker.sv
// Response-side checker for the ALU: queues {op, expected} per issued op, compares each result, counts pass/fail.
// Optional first-mismatch capture outputs are enabled with `define ALU_CHK_CAPTURE_EN.
module alu_result_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     exp_valid,
    output logic                     exp_ready,
    input  logic [2:0]               exp_op,
    input  logic [WIDTH-1:0]         exp_data,
    input  logic                     res_valid,
    input  logic [WIDTH-1:0]         res_data,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     timeout,
    output logic                     underflow
`ifdef ALU_CHK_CAPTURE_EN
    ,
    output logic                     cap_valid,
    output logic [2:0]               cap_op,
    output logic [WIDTH-1:0]         cap_exp,
    output logic [WIDTH-1:0]         cap_act
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
    logic [PW-1:0]      pending_r, pending_s;
    logic [TW-1:0]      wait_r, wait_s;
    logic [CNT_W-1:0]   pass_cnt_r, fail_cnt_r;
    logic               timeout_r, underflow_r;
    logic [WIDTH-1:0]   mem_data_r [DEPTH];

    logic empty_s, full_s, ready_s, push_s, pop_s, under_s, tmo_s, match_s;

    // Handshake, pop/underflow/timeout qualifiers and head compare
    always_comb begin
        empty_s = (pending_r == {PW{1'b0}});
        full_s  = (pending_r == FULL_LVL);
        ready_s = !full_s && (state_r != ST_ERR);
        push_s  = exp_valid && ready_s;
        pop_s   = res_valid && !empty_s && (state_r != ST_ERR);
        under_s = res_valid && empty_s && (state_r != ST_ERR);
        tmo_s   = !empty_s && (state_r != ST_ERR) && !pop_s && (wait_r == TMO_LAST);
        match_s = (res_data == mem_data_r[rd_ptr_r]);
    end

    // Next-state logic plus occupancy and wait-counter updates
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r;
        wait_s    = wait_r;
        case (state_r)
            ST_IDLE: begin
                if (under_s)     state_s = ST_ERR;
                else if (push_s) state_s = ST_WAIT;
                else             state_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (tmo_s)                                                  state_s = ST_ERR;
                else if (pop_s && !push_s && pending_r == PW'(1))           state_s = ST_IDLE;
                else                                                        state_s = ST_WAIT;
            end
            ST_ERR:  state_s = ST_ERR;
            default: state_s = ST_ERR;
        endcase
        case ({push_s, pop_s})
            2'b10:   pending_s = pending_r + PW'(1);
            2'b01:   pending_s = pending_r - PW'(1);
            default: pending_s = pending_r;
        endcase
        // The counter only ever runs while the head entry is outstanding and the checker is live
        if (state_r == ST_ERR)       wait_s = wait_r;
        else if (pop_s || empty_s)   wait_s = {TW{1'b0}};
        else                         wait_s = wait_r + TW'(1);
    end

    // Control, pointer, counter and sticky-flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            pending_r   <= {PW{1'b0}};
            wait_r      <= {TW{1'b0}};
            pass_cnt_r  <= {CNT_W{1'b0}};
            fail_cnt_r  <= {CNT_W{1'b0}};
            timeout_r   <= 1'b0;
            underflow_r <= 1'b0;
        end else if (clear) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            pending_r   <= {PW{1'b0}};
            wait_r      <= {TW{1'b0}};
            pass_cnt_r  <= {CNT_W{1'b0}};
            fail_cnt_r  <= {CNT_W{1'b0}};
            timeout_r   <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            wait_r    <= wait_s;
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                if (match_s && pass_cnt_r != {CNT_W{1'b1}})  pass_cnt_r <= pass_cnt_r + CNT_W'(1);
                if (!match_s && fail_cnt_r != {CNT_W{1'b1}}) fail_cnt_r <= fail_cnt_r + CNT_W'(1);
            end
            if (tmo_s)   timeout_r   <= 1'b1;
            if (under_s) underflow_r <= 1'b1;
        end
    end

    // Expectation storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_data_r[i] <= {WIDTH{1'b0}};
        end else if (push_s && !clear) begin
            mem_data_r[wr_ptr_r] <= exp_data;
        end
    end

`ifdef ALU_CHK_CAPTURE_EN
    logic [2:0]       mem_op_r [DEPTH];
    logic             cap_valid_r;
    logic [2:0]       cap_op_r;
    logic [WIDTH-1:0] cap_exp_r, cap_act_r;

    // Opcode storage alongside the expected data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_op_r[i] <= 3'd0;
        end else if (push_s && !clear) begin
            mem_op_r[wr_ptr_r] <= exp_op;
        end
    end

    // First-mismatch capture, held until clear or reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid_r <= 1'b0;
            cap_op_r    <= 3'd0;
            cap_exp_r   <= {WIDTH{1'b0}};
            cap_act_r   <= {WIDTH{1'b0}};
        end else if (clear) begin
            cap_valid_r <= 1'b0;
            cap_op_r    <= 3'd0;
            cap_exp_r   <= {WIDTH{1'b0}};
            cap_act_r   <= {WIDTH{1'b0}};
        end else if (pop_s && !match_s && !cap_valid_r) begin
            cap_valid_r <= 1'b1;
            cap_op_r    <= mem_op_r[rd_ptr_r];
            cap_exp_r   <= mem_data_r[rd_ptr_r];
            cap_act_r   <= res_data;
        end
    end

    assign cap_valid = cap_valid_r;
    assign cap_op    = cap_op_r;
    assign cap_exp   = cap_exp_r;
    assign cap_act   = cap_act_r;
`else
    logic unused_op_s;
    assign unused_op_s = ^exp_op;
`endif

    assign exp_ready = ready_s;
    assign pass_cnt  = pass_cnt_r;
    assign fail_cnt  = fail_cnt_r;
    assign pending   = pending_r;
    assign timeout   = timeout_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_alu_result_checker.sv
// Self-checking bench for alu_result_checker: directed scenarios plus random traffic against a queue-based model.
module tb_alu_result_checker;

    localparam int DEPTH = 8;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_ready;
    logic [2:0]  exp_op = 3'd0;
    logic [31:0] exp_data = 32'd0;
    logic        res_valid = 1'b0;
    logic [31:0] res_data = 32'd0;
    logic [15:0] pass_cnt, fail_cnt;
    logic [3:0]  pending;
    logic        timeout, underflow;
`ifdef ALU_CHK_CAPTURE_EN
    logic        cap_valid;
    logic [2:0]  cap_op;
    logic [31:0] cap_exp, cap_act;
`endif

    alu_result_checker #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_op(exp_op), .exp_data(exp_data),
        .res_valid(res_valid), .res_data(res_data),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .pending(pending),
        .timeout(timeout), .underflow(underflow)
`ifdef ALU_CHK_CAPTURE_EN
        , .cap_valid(cap_valid), .cap_op(cap_op), .cap_exp(cap_exp), .cap_act(cap_act)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: an ordinary queue of outstanding expectations plus counts and flags
    logic [31:0] mq_data[$];
    logic [2:0]  mq_op[$];
    int          m_pass, m_fail;
    bit          m_err, m_tmo, m_und;
    bit          m_cap_v;
    logic [2:0]  m_cap_op;
    logic [31:0] m_cap_exp, m_cap_act;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_data.delete();
        mq_op.delete();
        m_pass = 0; m_fail = 0;
        m_err = 1'b0; m_tmo = 1'b0; m_und = 1'b0;
        m_cap_v = 1'b0; m_cap_op = 3'd0; m_cap_exp = 32'd0; m_cap_act = 32'd0;
    endtask

    task automatic compare_outputs();
        check("pass_cnt", 64'(pass_cnt), 64'(m_pass));
        check("fail_cnt", 64'(fail_cnt), 64'(m_fail));
        check("pending", 64'(pending), 64'(mq_data.size()));
        check("timeout", 64'(timeout), 64'(m_tmo));
        check("underflow", 64'(underflow), 64'(m_und));
`ifdef ALU_CHK_CAPTURE_EN
        check("cap_valid", 64'(cap_valid), 64'(m_cap_v));
        if (m_cap_v) begin
            check("cap_op", 64'(cap_op), 64'(m_cap_op));
            check("cap_exp", 64'(cap_exp), 64'(m_cap_exp));
            check("cap_act", 64'(cap_act), 64'(m_cap_act));
        end
`endif
    endtask

    // One clock cycle: drive, check ready, clock, advance model, check outputs
    task automatic step(input bit ev, input logic [2:0] eop, input logic [31:0] ed,
                        input bit rv, input logic [31:0] rd, input bit clr, input bit tmo_now);
        bit rdy;
        bit push;
        exp_valid = ev; exp_op = eop; exp_data = ed;
        res_valid = rv; res_data = rd; clear = clr;
        #1;
        rdy = (mq_data.size() < DEPTH) && !m_err;
        check("exp_ready", 64'(exp_ready), 64'(rdy));
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            push = ev && rdy;
            if (!m_err && rv) begin
                if (mq_data.size() == 0) begin
                    m_und = 1'b1;
                    m_err = 1'b1;
                end else begin
                    logic [31:0] hd;
                    logic [2:0]  hop;
                    hd = mq_data.pop_front();
                    hop = mq_op.pop_front();
                    if (hd == rd) begin
                        if (m_pass < 65535) m_pass++;
                    end else begin
                        if (m_fail < 65535) m_fail++;
                        if (!m_cap_v) begin
                            m_cap_v = 1'b1; m_cap_op = hop; m_cap_exp = hd; m_cap_act = rd;
                        end
                    end
                end
            end
            if (push) begin
                mq_data.push_back(ed);
                mq_op.push_back(eop);
            end
            if (tmo_now) begin
                m_tmo = 1'b1;
                m_err = 1'b1;
            end
        end
        #1;
        exp_valid = 1'b0; res_valid = 1'b0; clear = 1'b0;
        compare_outputs();
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] d;
        model_reset();
        #3;
        compare_outputs();
        check("reset_ready", 64'(exp_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: NOT op, matching result
        step(1'b1, 3'b110, 32'h32F52F8B, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'd0, 1'b1, 32'h32F52F8B, 1'b0, 1'b0);
        check("t1_pass", 64'(pass_cnt), 64'd1);
        check("t1_pending", 64'(pending), 64'd0);

        // 2: mismatch by one bit
        step(1'b1, 3'b110, 32'hCB14AEFC, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'd0, 1'b1, 32'hCB14AEFD, 1'b0, 1'b0);
        check("t2_fail", 64'(fail_cnt), 64'd1);
`ifdef ALU_CHK_CAPTURE_EN
        check("t2_cap_op", 64'(cap_op), 64'b110);
        check("t2_cap_act", 64'(cap_act), 64'hCB14AEFD);
`endif

        // 3: fill, refused push with same-cycle pop, drain across the wrap
        do_clear();
        idle();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 3'(i), 32'h1000 + 32'(i), 1'b0, 32'd0, 1'b0, 1'b0);
        check("t3_full", 64'(pending), 64'd8);
        step(1'b1, 3'd7, 32'hDEAD, 1'b1, 32'h1000, 1'b0, 1'b0);
        check("t3_refused", 64'(pending), 64'd7);
        for (int i = 1; i < DEPTH; i++) step(1'b0, 3'd0, 32'd0, 1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
        check("t3_pass", 64'(pass_cnt), 64'd8);
        check("t3_empty", 64'(pending), 64'd0);

        // 4: timeout exactly TIMEOUT cycles after the push
        step(1'b1, 3'd2, 32'hABCD, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 1; i < TIMEOUT; i++) idle();
        check("t4_not_yet", 64'(timeout), 64'd0);
        step(1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        check("t4_timeout", 64'(timeout), 64'd1);
        step(1'b1, 3'd0, 32'h5, 1'b1, 32'hABCD, 1'b0, 1'b0);
        check("t4_frozen", 64'(pass_cnt), 64'd8);
        do_clear();
        idle();
        check("t4_ready", 64'(exp_ready), 64'd1);

        // 5: result with nothing queued
        step(1'b0, 3'd0, 32'd0, 1'b1, 32'h77, 1'b0, 1'b0);
        check("t5_und", 64'(underflow), 64'd1);
        check("t5_ready", 64'(exp_ready), 64'd0);
        do_clear();
        idle();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            bit ev, rv, clr;
            ev = ($urandom % 2) == 0;
            rv = ($urandom % 2) == 0;
            clr = (($urandom % 64) == 0) || (m_err && ($urandom % 4) == 0);
            if (mq_data.size() > 0 && ($urandom % 4) != 0) d = mq_data[0];
            else d = $urandom;
            step(ev, 3'($urandom_range(0, 7)), $urandom, rv, d, clr, 1'b0);
        end

        // 6: asynchronous reset mid-stream
        do_clear();
        for (int i = 0; i < 3; i++) step(1'b1, 3'd1, 32'(i), 1'b0, 32'd0, 1'b0, 1'b0);
        check("t6_before", 64'(pending), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_pending", 64'(pending), 64'd0);
        check("t6_pass", 64'(pass_cnt), 64'd0);
        check("t6_fail", 64'(fail_cnt), 64'd0);
        check("t6_flags", 64'({timeout, underflow}), 64'd0);
        #1;
        rst_n = 1'b1;
        idle();
        step(1'b0, 3'd0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
